// File: rtl/lcd_frame_capture.sv
// Packs 2-bit PPU pixels four to a byte into a double-buffered framebuffer and
// swaps display/capture banks at end of frame once the display reader is idle.
module lcd_frame_capture #(
  parameter int H_PX = 160,
  parameter int V_PX = 144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  px_in,
  input  logic        px_valid,
  input  logic        frame_sync,
  input  logic        rd_busy,
  input  logic        err_clr,
  output logic        fb_wr_en,
  output logic [13:0] fb_wr_addr,
  output logic [7:0]  fb_wr_data,
  output logic        rd_bank,
  output logic        frame_done,
  output logic        overrun,
  output logic        short_frame
);

  localparam int XW = (H_PX > 1) ? $clog2(H_PX) : 1;
  localparam int YW = (V_PX > 1) ? $clog2(V_PX) : 1;
  localparam logic [12:0]   LINE_BYTES = 13'(H_PX / 4);
  localparam logic [XW-1:0] X_LAST     = XW'(H_PX - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(V_PX - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_SWAP} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [7:0]    shift_q, shift_d;
  logic          fb_wr_en_q, fb_wr_en_d;
  logic [13:0]   fb_wr_addr_q, fb_wr_addr_d;
  logic [7:0]    fb_wr_data_q, fb_wr_data_d;
  logic          rd_bank_q, rd_bank_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q, overrun_d;
  logic          short_frame_q, short_frame_d;

  logic          restart;
  logic          accept;
  logic          last_px;
  logic          swap;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic [12:0]   byte_idx;

  // A sync pulse repositions the current pixel slot to (0,0) in the same cycle,
  // so a pixel arriving alongside it is placed as the first pixel of the frame.
  always_comb begin
    restart  = frame_sync && (state_q == IDLE || state_q == CAPTURE);
    accept   = px_valid && (state_q == CAPTURE || restart);
    cur_x    = restart ? '0 : x_q;
    cur_y    = restart ? '0 : y_q;
    last_px  = accept && (cur_x == X_LAST) && (cur_y == Y_LAST);
    swap     = (state_q == WAIT_SWAP) && !rd_busy;
    byte_idx = 13'(cur_y) * LINE_BYTES + 13'(cur_x >> 2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (restart) state_d = last_px ? WAIT_SWAP : CAPTURE;
      CAPTURE:   if (last_px) state_d = WAIT_SWAP;
      WAIT_SWAP: if (swap)    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    shift_d       = shift_q;
    fb_wr_en_d    = 1'b0;
    fb_wr_addr_d  = fb_wr_addr_q;
    fb_wr_data_d  = fb_wr_data_q;
    rd_bank_d     = rd_bank_q ^ swap;
    frame_done_d  = swap;
    // Sticky flags: a fresh error in the clearing cycle keeps the flag set.
    overrun_d     = (overrun_q && !err_clr) ||
                    ((state_q == WAIT_SWAP) && (px_valid || frame_sync));
    short_frame_d = (short_frame_q && !err_clr) ||
                    ((state_q == CAPTURE) && frame_sync && ((x_q != '0) || (y_q != '0)));

    if (restart) begin
      x_d     = '0;
      y_d     = '0;
      shift_d = '0;
    end

    if (accept) begin
      case (cur_x[1:0])
        2'd0:    shift_d[1:0] = px_in;
        2'd1:    shift_d[3:2] = px_in;
        2'd2:    shift_d[5:4] = px_in;
        default: shift_d[7:6] = px_in;
      endcase

      if (cur_x[1:0] == 2'd3) begin
        fb_wr_en_d   = 1'b1;
        fb_wr_addr_d = {~rd_bank_q, byte_idx};
        fb_wr_data_d = shift_d;
      end

      if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q           <= '0;
      y_q           <= '0;
      shift_q       <= '0;
      fb_wr_en_q    <= 1'b0;
      fb_wr_addr_q  <= '0;
      fb_wr_data_q  <= '0;
      rd_bank_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      short_frame_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      shift_q       <= shift_d;
      fb_wr_en_q    <= fb_wr_en_d;
      fb_wr_addr_q  <= fb_wr_addr_d;
      fb_wr_data_q  <= fb_wr_data_d;
      rd_bank_q     <= rd_bank_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      short_frame_q <= short_frame_d;
    end
  end

  assign fb_wr_en    = fb_wr_en_q;
  assign fb_wr_addr  = fb_wr_addr_q;
  assign fb_wr_data  = fb_wr_data_q;
  assign rd_bank     = rd_bank_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign short_frame = short_frame_q;

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Directed bench for lcd_frame_capture: a vector table for packing, sync and
// reset cases, then full-frame, swap-stall and short-frame sequences.
module tb_lcd_frame_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  px_in = 2'd0;
  logic        px_valid = 1'b0;
  logic        frame_sync = 1'b0;
  logic        rd_busy = 1'b0;
  logic        err_clr = 1'b0;
  logic        fb_wr_en;
  logic [13:0] fb_wr_addr;
  logic [7:0]  fb_wr_data;
  logic        rd_bank;
  logic        frame_done;
  logic        overrun;
  logic        short_frame;

  lcd_frame_capture #(.H_PX(160), .V_PX(144)) dut (
    .clk(clk), .rst(rst), .px_in(px_in), .px_valid(px_valid),
    .frame_sync(frame_sync), .rd_busy(rd_busy), .err_clr(err_clr),
    .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
    .rd_bank(rd_bank), .frame_done(frame_done), .overrun(overrun),
    .short_frame(short_frame)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        rst;
    logic        fs;
    logic        pv;
    logic [1:0]  px;
    logic        clr;
    logic        chk_ad;
    logic        e_we;
    logic [13:0] e_addr;
    logic [7:0]  e_data;
    logic        e_bank;
    logic        e_done;
    logic        e_ovr;
    logic        e_short;
  } vec_t;

  vec_t vt [22];

  function automatic vec_t mk(input int rst_i, input int fs_i, input int pv_i, input int px_i,
                              input int clr_i, input int we_i, input int addr_i, input int data_i,
                              input int short_i, input int chk_i);
    vec_t v;
    v.rst     = 1'(rst_i);
    v.fs      = 1'(fs_i);
    v.pv      = 1'(pv_i);
    v.px      = 2'(px_i);
    v.clr     = 1'(clr_i);
    v.chk_ad  = 1'(chk_i);
    v.e_we    = 1'(we_i);
    v.e_addr  = 14'(addr_i);
    v.e_data  = 8'(data_i);
    v.e_bank  = 1'b0;
    v.e_done  = 1'b0;
    v.e_ovr   = 1'b0;
    v.e_short = 1'(short_i);
    return v;
  endfunction

  // Deterministic pixel pattern and its packed byte (pixel p in the low bits).
  function automatic logic [1:0] pix(input int p);
    int v;
    v = p ^ (p >> 3) ^ (p >> 7);
    return v[1:0];
  endfunction

  function automatic logic [7:0] pack(input int p);
    return {pix(p + 3), pix(p + 2), pix(p + 1), pix(p)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are read just after the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Write monitor: counts writes and frame_done pulses, optionally checks the
  // address/data sequence of a full frame against the pixel pattern.
  logic        mon_clr = 1'b0;
  logic        seq_on = 1'b0;
  logic [13:0] seq_base = 14'h0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          seq_err = 0;
  int          exp_byte = 0;
  logic [13:0] last_addr = 14'h0;
  logic [7:0]  last_data = 8'h0;

  always @(negedge clk) begin
    if (mon_clr) begin
      wr_cnt   <= 0;
      done_cnt <= 0;
      seq_err  <= 0;
      exp_byte <= 0;
    end else begin
      if (fb_wr_en === 1'b1) begin
        wr_cnt    <= wr_cnt + 1;
        last_addr <= fb_wr_addr;
        last_data <= fb_wr_data;
        if (seq_on) begin
          if (fb_wr_addr !== seq_base + 14'(exp_byte) || fb_wr_data !== pack(4 * exp_byte))
            seq_err <= seq_err + 1;
          exp_byte <= exp_byte + 1;
        end
      end
      if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end
  end

  task automatic clear_monitor();
    mon_clr = 1'b1;
    cyc();
    mon_clr = 1'b0;
  endtask

  task automatic stream(input int n, input int p0);
    for (int i = 0; i < n; i++) begin
      frame_sync = (i == 0);
      px_valid   = 1'b1;
      px_in      = pix(p0 + i);
      cyc();
    end
    frame_sync = 1'b0;
    px_valid   = 1'b0;
  endtask

  task automatic settle_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 20) begin
      cyc();
      n++;
    end
    for (int i = 0; i < 5; i++) cyc();
  endtask

  initial begin
    vt[0]  = mk(1, 0, 0, 0, 0, 0, 0,       0,    0, 1);
    vt[1]  = mk(0, 0, 1, 3, 0, 0, 0,       0,    0, 0);
    vt[2]  = mk(0, 1, 1, 1, 0, 0, 0,       0,    0, 0);
    vt[3]  = mk(0, 0, 1, 2, 0, 0, 0,       0,    0, 0);
    vt[4]  = mk(0, 0, 1, 3, 0, 0, 0,       0,    0, 0);
    vt[5]  = mk(0, 0, 1, 0, 0, 1, 'h2000, 'h39,  0, 1);
    vt[6]  = mk(0, 0, 0, 0, 0, 0, 0,       0,    0, 0);
    vt[7]  = mk(0, 0, 1, 0, 0, 0, 0,       0,    0, 0);
    vt[8]  = mk(0, 0, 1, 0, 0, 0, 0,       0,    0, 0);
    vt[9]  = mk(0, 0, 1, 0, 0, 0, 0,       0,    0, 0);
    vt[10] = mk(0, 0, 1, 3, 0, 1, 'h2001, 'hC0,  0, 1);
    vt[11] = mk(0, 1, 1, 2, 0, 0, 0,       0,    1, 0);
    vt[12] = mk(0, 0, 0, 0, 1, 0, 0,       0,    0, 0);
    vt[13] = mk(0, 1, 1, 1, 1, 0, 0,       0,    1, 0);
    vt[14] = mk(0, 0, 1, 1, 0, 0, 0,       0,    1, 0);
    vt[15] = mk(0, 0, 1, 1, 0, 0, 0,       0,    1, 0);
    vt[16] = mk(0, 0, 1, 1, 0, 1, 'h2000, 'h55,  1, 1);
    vt[17] = mk(0, 0, 1, 2, 0, 0, 0,       0,    1, 0);
    vt[18] = mk(0, 0, 1, 2, 0, 0, 0,       0,    1, 0);
    vt[19] = mk(0, 0, 1, 2, 0, 0, 0,       0,    1, 0);
    vt[20] = mk(1, 0, 1, 2, 0, 0, 0,       0,    0, 1);
    vt[21] = mk(0, 0, 1, 2, 0, 0, 0,       0,    0, 0);

    for (int i = 0; i < 22; i++) begin
      rst        = vt[i].rst;
      frame_sync = vt[i].fs;
      px_valid   = vt[i].pv;
      px_in      = vt[i].px;
      err_clr    = vt[i].clr;
      rd_busy    = 1'b0;
      cyc();
      $display("vec %0d: we=%0b addr=%h data=%h bank=%0b done=%0b ovr=%0b short=%0b",
               i, fb_wr_en, fb_wr_addr, fb_wr_data, rd_bank, frame_done, overrun, short_frame);
      chk($sformatf("vec%0d flags", i),
          32'({fb_wr_en, rd_bank, frame_done, overrun, short_frame}),
          32'({vt[i].e_we, vt[i].e_bank, vt[i].e_done, vt[i].e_ovr, vt[i].e_short}));
      if (vt[i].chk_ad) begin
        chk($sformatf("vec%0d addr", i), 32'(fb_wr_addr), 32'(vt[i].e_addr));
        chk($sformatf("vec%0d data", i), 32'(fb_wr_data), 32'(vt[i].e_data));
      end
    end
    rst = 1'b0; frame_sync = 1'b0; px_valid = 1'b0; err_clr = 1'b0;

    // Full frame into bank 1, then swap with the reader idle.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    seq_base = 14'h2000;
    seq_on   = 1'b1;
    clear_monitor();
    stream(23040, 0);
    settle_done();
    $display("full frame: writes=%0d seq_err=%0d last=%h done=%0d bank=%0b",
             wr_cnt, seq_err, last_addr, done_cnt, rd_bank);
    chk("full writes", 32'(wr_cnt), 32'd5760);
    chk("full sequence", 32'(seq_err), 32'd0);
    chk("full last addr", 32'(last_addr), 32'h367F);
    chk("full frame_done", 32'(done_cnt), 32'd1);
    chk("full rd_bank", 32'(rd_bank), 32'd1);
    chk("full overrun", 32'(overrun), 32'd0);

    // Full frame into bank 0 while the reader holds the bank busy.
    seq_base = 14'h0000;
    rd_busy  = 1'b1;
    clear_monitor();
    stream(23040, 0);
    for (int i = 0; i < 100; i++) begin
      px_valid = (i % 20 == 5);
      px_in    = 2'd3;
      cyc();
    end
    px_valid = 1'b0;
    $display("stall: writes=%0d seq_err=%0d done=%0d ovr=%0b bank=%0b",
             wr_cnt, seq_err, done_cnt, overrun, rd_bank);
    chk("stall writes", 32'(wr_cnt), 32'd5760);
    chk("stall sequence", 32'(seq_err), 32'd0);
    chk("stall no frame_done", 32'(done_cnt), 32'd0);
    chk("stall overrun", 32'(overrun), 32'd1);
    chk("stall rd_bank held", 32'(rd_bank), 32'd1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    $display("stall err_clr: ovr=%0b", overrun);
    chk("stall err_clr", 32'(overrun), 32'd0);
    frame_sync = 1'b1;
    cyc();
    frame_sync = 1'b0;
    $display("stall sync: ovr=%0b done=%0d", overrun, done_cnt);
    chk("stall sync overrun", 32'(overrun), 32'd1);
    rd_busy = 1'b0;
    settle_done();
    $display("stall release: done=%0d bank=%0b writes=%0d", done_cnt, rd_bank, wr_cnt);
    chk("stall release done", 32'(done_cnt), 32'd1);
    chk("stall release bank", 32'(rd_bank), 32'd0);
    chk("stall release writes", 32'(wr_cnt), 32'd5760);

    // Short frame: sync after two pixels of line 3 restarts bank 1 at byte 0.
    seq_on  = 1'b0;
    err_clr = 1'b1;
    clear_monitor();
    err_clr = 1'b0;
    stream(482, 0);
    $display("short pre: writes=%0d last=%h short=%0b", wr_cnt, last_addr, short_frame);
    chk("short pre writes", 32'(wr_cnt), 32'd120);
    chk("short pre last addr", 32'(last_addr), 32'h2077);
    chk("short pre flag", 32'(short_frame), 32'd0);
    stream(4, 1000);
    $display("short post: writes=%0d last=%h data=%h short=%0b bank=%0b",
             wr_cnt, last_addr, last_data, short_frame, rd_bank);
    chk("short flag", 32'(short_frame), 32'd1);
    chk("short writes", 32'(wr_cnt), 32'd121);
    chk("short restart addr", 32'(last_addr), 32'h2000);
    chk("short restart data", 32'(last_data), 32'(pack(1000)));
    chk("short no swap", 32'({rd_bank, 1'b0} | 2'(done_cnt)), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_frame_capture.md
LCD_FRAME_CAPTURE -- requirements
Module: lcd_frame_capture

Interface
REQ-001 SHALL have clk, input, 1, system clock; all logic on rising edge.
REQ-002 SHALL have rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have px_in, input, 2, PPU pixel shade 0-3.
REQ-004 SHALL have px_valid, input, 1, px_in qualifier; one pixel per asserted cycle.
REQ-005 SHALL have frame_sync, input, 1, one-cycle pulse marking the first pixel slot of a frame.
REQ-006 SHALL have rd_busy, input, 1, display reader is scanning rd_bank; high blocks bank swap.
REQ-007 SHALL have err_clr, input, 1, clears sticky error flags.
REQ-008 SHALL have fb_wr_en, output, 1, framebuffer byte write strobe.
REQ-009 SHALL have fb_wr_addr, output, 14, {bank, byte index 0-5759}.
REQ-010 SHALL have fb_wr_data, output, 8, four packed pixels.
REQ-011 SHALL have rd_bank, output, 1, bank the display reader uses.
REQ-012 SHALL have frame_done, output, 1, one-cycle pulse on bank swap.
REQ-013 SHALL have overrun, output, 1, sticky: pixel or sync arrived while swap pending.
REQ-014 SHALL have short_frame, output, 1, sticky: frame_sync arrived mid-frame.
REQ-015 SHALL use parameters H_PX (default 160, pixels/line) and V_PX (default 144, lines/frame).

Function
REQ-016 SHALL implement states IDLE, CAPTURE, WAIT_SWAP.
REQ-017 SHALL stay in IDLE ignoring px_valid until frame_sync; frame_sync moves to CAPTURE with x=0, y=0.
REQ-018 SHALL treat px_valid asserted in the same cycle as frame_sync as pixel (0,0) of the new frame.
REQ-019 SHALL, in CAPTURE, place each accepted pixel at shift-register bits [2*(x mod 4)+1 : 2*(x mod 4)].
REQ-020 SHALL pulse fb_wr_en for one cycle, exactly one cycle after the pixel with x mod 4 = 3 is accepted.
REQ-021 SHALL drive fb_wr_addr = {wr_bank, y*(H_PX/4) + x/4} for that byte; the inverse of rd_bank is wr_bank.
REQ-022 SHALL increment x per accepted pixel; at x=H_PX-1, wrap x to 0 and increment y.
REQ-023 SHALL, on accepting pixel (H_PX-1, V_PX-1), enter WAIT_SWAP after issuing that final byte write.
REQ-024 SHALL, in WAIT_SWAP with rd_busy low, toggle rd_bank, pulse frame_done for one cycle, and go to IDLE.
REQ-025 SHALL, in WAIT_SWAP, drop px_valid pixels and frame_sync pulses, and set overrun for either.
REQ-026 SHALL, on frame_sync in CAPTURE unless x=0 and y=0, do the following:
- set short_frame;
- discard any partial byte;
- restart at (0,0) on the same wr_bank with no swap.
REQ-027 SHALL never assert fb_wr_en outside CAPTURE, except for the final-byte write of REQ-023.
REQ-028 SHALL clear overrun and short_frame on err_clr; a set condition in the same cycle wins.
REQ-029 SHALL use combinational address arithmetic no wider than 13 bits for the byte index (max 5759).

Reset
REQ-030 SHALL, on rst, do the following regardless of state or partial byte:
- enter IDLE;
- set x=0, y=0;
- clear the shift register;
- set rd_bank=0 (wr_bank=1);
- set fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0, frame_done=0, overrun=0, short_frame=0.
REQ-031 SHALL produce no write in the cycle after rst deasserts, even if a byte was one pixel from completion at reset.

Verification
REQ-032 SHALL verify full frame:
- stimulus: rst, then frame_sync, then 23040 valid pixels with rd_busy=0;
- response: 5760 writes to addresses 0x2000-0x367F, then frame_done once, rd_bank=1.
REQ-033 SHALL verify packing:
- stimulus: pixels 1,2,3,0 at x=0-3;
- response: fb_wr_data=0x39 at address 0x2000 one cycle after the 4th pixel.
REQ-034 SHALL verify swap stall:
- stimulus: frame completes while rd_busy=1 for 100 cycles, with 5 px_valid pulses meanwhile;
- response: no frame_done until rd_busy falls, overrun=1, no writes.
REQ-035 SHALL verify short frame:
- stimulus: frame_sync after 2 pixels of line 3;
- response: short_frame=1, partial byte dropped, next write at byte 0 of the same bank.
REQ-036 SHALL verify reset mid-frame:
- stimulus: rst asserted after pixel x=2;
- response: no write follows, and all outputs match REQ-030 values.
REQ-037 SHALL verify simultaneous sync and pixel:
- stimulus: frame_sync and px_valid both high in IDLE;
- response: that pixel lands in bits [1:0] of byte 0.
